cr_rbus_master: RTL
===================

# cr_rbus_master

Register-bus ring initiator for the crypto/compression block set. It accepts single register read/write requests from a local host-side agent (CSR bridge or debug engine) and launches each as one rbus transaction onto the outbound ring. It then waits for the ack/err_ack that returns after the transaction has passed through every block regfile responder on the ring, and hands back read data plus status. It is the origin and termination point of the `rbus_ring_t` ring that each block's regfile joins through `nx_rbus_ring`.

## Interface
Parameters:
- N_RBUS_ADDR_BITS, default `N_RBUS_ADDR_BITS: ring address width.
- N_RBUS_DATA_BITS, default `N_RBUS_DATA_BITS: ring data width (32).
- TIMEOUT_CYCLES, default 1024: number of WAIT cycles without ack before the transaction is abandoned.

Ports:
- clk  in  1  the block's only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  host request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  N_RBUS_ADDR_BITS  target ring address.
- req_wdata  in  N_RBUS_DATA_BITS  write data.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  host takes the response.
- rsp_rdata  out  N_RBUS_DATA_BITS  read data; 0 for writes, error responses and timeouts.
- rsp_err  out  1  the transaction returned err_ack.
- rsp_timeout  out  1  no ack arrived within TIMEOUT_CYCLES.
- rbus_ring_o  out  rbus_ring_t  outbound ring, toward the first responder.
- rbus_ring_i  in  rbus_ring_t  inbound ring, returning from the last responder.
- stale_ack_cnt  out  8  saturating count of ack/err_ack pulses received while not in WAIT.

## Operation
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE: a handshake (req_valid & req_ready) captures wr, addr and wdata, then moves to ISSUE.
- ISSUE (exactly 1 cycle):
  - rbus_ring_o.wr_strb = req_wr; rbus_ring_o.rd_strb = ~req_wr.
  - Move to WAIT and clear the timeout counter.
- WAIT:
  - rbus_ring_i.err_ack → RESP with rsp_err=1, rdata=0.
  - Otherwise rbus_ring_i.ack → RESP with rdata captured from rbus_ring_i.rd_data on reads, 0 on writes.
  - Otherwise, when counter == TIMEOUT_CYCLES-1 → RESP with rsp_timeout=1.
  - Otherwise the counter increments.
- RESP: rsp_valid=1 and response fields stable; rsp_valid & rsp_ready → IDLE.
- rbus_ring_o.addr and wr_data hold the captured values from ISSUE through RESP, and keep the last value in IDLE.
- The master terminates the ring, so rbus_ring_o.rd_data, .ack and .err_ack are always 0.
- Precedence within one cycle: err_ack beats ack, and ack beats timeout. An ack arriving in the same cycle the counter hits its limit is a success.
- An ack or err_ack seen in IDLE, ISSUE or RESP (for example a late ack after a timeout) is dropped and increments stale_ack_cnt, which saturates at 255. It never produces a response.
- Only one transaction is ever outstanding.

## Timing
- Reset values: all rbus_ring_o fields 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, stale_ack_cnt=0, FSM in IDLE.
- Assertion of rst_n low in any state forces reset values immediately. Nothing is replayed; a later returning ack counts as stale.
- All outputs are registered. A handshake at cycle T puts the strobe on rbus_ring_o at T+1, for one cycle only.
- An ack seen on rbus_ring_i at cycle A gives rsp_valid at A+1. The earliest response is therefore T+3 for a zero-latency ring.
- Timeout: rsp_valid rises TIMEOUT_CYCLES+2 cycles after the handshake.
- req_ready is low from T+1 until the cycle after the rsp handshake, so back-to-back requests are spaced at least 4 cycles apart.
- rsp_ready may be held high permanently; the response still lasts 1 cycle.

## Structure
- cr_rbus_masterPKG holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the response struct {rdata, err, timeout};
  - the timeout counter width localparam, $clog2(TIMEOUT_CYCLES).
- rbus_ring_t and the N_RBUS_* macros continue to come from the shared cr_structs/global headers.
- No sub-module: the block is a single FSM plus a counter.

## Test plan
- Write at addr 0x0100, data 0xDEADBEEF, with a responder that acks after 5 cycles → exactly 1-cycle wr_strb at T+1 carrying addr 0x0100 and data 0xDEADBEEF; rsp_valid at T+7 with err=0, timeout=0, rdata=0.
- Read at addr 0x0200, responder returns rd_data 0x12345678 with ack → rsp_rdata=0x12345678, rd_strb pulsed once, wr_strb never asserted.
- Read at an unmapped address, responder returns err_ack (with ack asserted in the same cycle) → rsp_err=1, rdata=0.
- TIMEOUT_CYCLES=16, no responder → rsp_timeout=1 at T+18. An ack injected 3 cycles later → stale_ack_cnt=1 and no rsp_valid.
- Ack arriving exactly in the counter-limit cycle → success response with timeout=0. Separately, rsp_ready held low for 10 cycles → rsp fields stable and req_ready=0 throughout.
- rst_n asserted mid-WAIT → all outputs at reset values in the same cycle, FSM in IDLE, and a new request is accepted normally after rst_n deasserts.

Source files
------------

// File: rtl/cr_rbus_master_pkg.sv
// Shared types for the rbus ring initiator: ring transaction struct, FSM states, response record.
// Ring widths mirror the global N_RBUS_* defaults so the struct stays a fixed packed type.
package cr_rbus_master_pkg;

    localparam int unsigned RbusAddrBits      = 16;
    localparam int unsigned RbusDataBits      = 32;
    localparam int unsigned TimeoutCyclesDflt = 1024;
    localparam int unsigned TimeoutCntW       = $clog2(TimeoutCyclesDflt);

    typedef struct packed {
        logic [RbusAddrBits-1:0] addr;
        logic                    wr_strb;
        logic                    rd_strb;
        logic [RbusDataBits-1:0] wr_data;
        logic [RbusDataBits-1:0] rd_data;
        logic                    ack;
        logic                    err_ack;
    } rbus_ring_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    typedef struct packed {
        logic [RbusDataBits-1:0] rdata;
        logic                    err;
        logic                    timeout;
    } rsp_t;

    // A one-cycle timeout still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/cr_rbus_master.sv
// Register-bus ring initiator: launches one host request onto the ring, waits for the
// returning ack/err_ack (or times out) and presents a registered response.
module cr_rbus_master
    import cr_rbus_master_pkg::*;
#(
    parameter int unsigned N_RBUS_ADDR_BITS = RbusAddrBits,
    parameter int unsigned N_RBUS_DATA_BITS = RbusDataBits,
    parameter int unsigned TIMEOUT_CYCLES   = TimeoutCyclesDflt
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic [N_RBUS_ADDR_BITS-1:0] req_addr,
    input  logic [N_RBUS_DATA_BITS-1:0] req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [N_RBUS_DATA_BITS-1:0] rsp_rdata,
    output logic                        rsp_err,
    output logic                        rsp_timeout,
    output rbus_ring_t                  rbus_ring_o,
    input  rbus_ring_t                  rbus_ring_i,
    output logic [7:0]                  stale_ack_cnt
);

    localparam int unsigned     CntW    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_e                      state_q;
    logic                        wr_q;
    logic [N_RBUS_ADDR_BITS-1:0] addr_q;
    logic [N_RBUS_DATA_BITS-1:0] wdata_q;
    logic                        wr_strb_q;
    logic                        rd_strb_q;
    logic                        req_ready_q;
    logic                        rsp_valid_q;
    rsp_t                        rsp_q;
    logic [CntW-1:0]             cnt_q;
    logic [7:0]                  stale_q;
    logic [7:0]                  stale_d;
    logic                        any_ack;

    assign any_ack = rbus_ring_i.ack | rbus_ring_i.err_ack;

    // Acks outside WAIT belong to no live transaction (late, or from before a reset).
    always_comb begin
        stale_d = stale_q;
        if (any_ack && (state_q != StWait) && (stale_q != 8'hFF)) begin
            stale_d = stale_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_strb_q   <= 1'b0;
            rd_strb_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            cnt_q       <= '0;
            stale_q     <= '0;
        end else begin
            stale_q   <= stale_d;
            wr_strb_q <= 1'b0;
            rd_strb_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        wr_q        <= req_wr;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        wr_strb_q   <= req_wr;
                        rd_strb_q   <= ~req_wr;
                        req_ready_q <= 1'b0;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (rbus_ring_i.err_ack) begin
                        rsp_q       <= '{rdata: '0, err: 1'b1, timeout: 1'b0};
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (rbus_ring_i.ack) begin
                        rsp_q.rdata   <= wr_q ? '0 : rbus_ring_i.rd_data;
                        rsp_q.err     <= 1'b0;
                        rsp_q.timeout <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StResp;
                    end else if (cnt_q == CntLast) begin
                        rsp_q       <= '{rdata: '0, err: 1'b0, timeout: 1'b1};
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The master terminates the ring: return-path fields are never driven outward.
    always_comb begin
        rbus_ring_o         = '0;
        rbus_ring_o.addr    = addr_q;
        rbus_ring_o.wr_data = wdata_q;
        rbus_ring_o.wr_strb = wr_strb_q;
        rbus_ring_o.rd_strb = rd_strb_q;
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_q.rdata;
    assign rsp_err       = rsp_q.err;
    assign rsp_timeout   = rsp_q.timeout;
    assign stale_ack_cnt = stale_q;

    logic unused_ring_in;
    assign unused_ring_in = ^{rbus_ring_i.addr, rbus_ring_i.wr_strb, rbus_ring_i.rd_strb,
                              rbus_ring_i.wr_data};

endmodule
